// File: rtl/axil_master_port.sv
// AXI4-Lite initiator: turns single-beat local commands into AXI4-Lite write
// or read transactions, one at a time, with an optional watchdog timeout.
module axil_master_port #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                    s0_axi_aclk,
  input  logic                    s0_axi_aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   m0_axi_awaddr,
  output logic                    m0_axi_awvalid,
  input  logic                    m0_axi_awready,
  output logic [DATA_WIDTH-1:0]   m0_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m0_axi_wstrb,
  output logic                    m0_axi_wvalid,
  input  logic                    m0_axi_wready,
  input  logic [1:0]              m0_axi_bresp,
  input  logic                    m0_axi_bvalid,
  output logic                    m0_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m0_axi_araddr,
  output logic                    m0_axi_arvalid,
  input  logic                    m0_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m0_axi_rdata,
  input  logic [1:0]              m0_axi_rresp,
  input  logic                    m0_axi_rvalid,
  output logic                    m0_axi_rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  // One extra bit so the counter can pass the limit without wrapping.
  localparam int WDOG_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WDOG_W-1:0] WDOG_LAST =
      WDOG_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR      = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_DATA = 3'd4;
  localparam logic [2:0] ST_RSP     = 3'd5;

  logic [2:0]            state_q, state_d;
  logic                  aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [WDOG_W-1:0]     wdog_q, wdog_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  write_q, write_d;
  logic                  awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic                  arvalid_q, arvalid_d, rready_q, rready_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_write_q, rsp_write_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [1:0]            rsp_resp_q, rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;
  logic                  cmd_ready_q, cmd_ready_d, busy_q, busy_d;
  logic                  wdog_hit, timeout_now, aw_hs, w_hs;

  assign wdog_hit = (TIMEOUT_CYCLES > 0) && (wdog_q >= WDOG_LAST);
  assign aw_hs    = awvalid_q && m0_axi_awready;
  assign w_hs     = wvalid_q && m0_axi_wready;

  // Next-state logic; a real completion on the watchdog edge wins over the timeout.
  always_comb begin
    state_d       = state_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    wdog_d        = wdog_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    write_d       = write_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_write_d   = rsp_write_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    timeout_now   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          wstrb_d   = cmd_wstrb;
          write_d   = cmd_write;
          wdog_d    = '0;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          if (cmd_write) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = ST_RD_ADDR;
          end
        end
      end
      ST_WR: begin
        wdog_d    = wdog_q + WDOG_W'(1);
        aw_done_d = aw_done_q || aw_hs;
        w_done_d  = w_done_q || w_hs;
        if (aw_hs) awvalid_d = 1'b0;
        if (w_hs)  wvalid_d  = 1'b0;
        if (aw_done_d && w_done_d) begin
          bready_d = 1'b1;
          state_d  = ST_WR_RESP;
        end else if (wdog_hit) begin
          timeout_now = 1'b1;
        end
      end
      ST_WR_RESP: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (m0_axi_bvalid && bready_q) begin
          bready_d      = 1'b0;
          rsp_resp_d    = m0_axi_bresp;
          rsp_write_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end else if (wdog_hit) begin
          timeout_now = 1'b1;
        end
      end
      ST_RD_ADDR: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (arvalid_q && m0_axi_arready) begin
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          state_d   = ST_RD_DATA;
        end else if (wdog_hit) begin
          timeout_now = 1'b1;
        end
      end
      ST_RD_DATA: begin
        wdog_d = wdog_q + WDOG_W'(1);
        if (m0_axi_rvalid && rready_q) begin
          rready_d      = 1'b0;
          rsp_rdata_d   = m0_axi_rdata;
          rsp_resp_d    = m0_axi_rresp;
          rsp_write_d   = 1'b0;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RSP;
        end else if (wdog_hit) begin
          timeout_now = 1'b1;
        end
      end
      ST_RSP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Watchdog recovery: abandon every channel and report SLVERR.
    if (timeout_now) begin
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_resp_d    = 2'b10;
      rsp_timeout_d = 1'b1;
      rsp_rdata_d   = '0;
      rsp_write_d   = write_q;
      state_d       = ST_RSP;
    end
  end

  // cmd_ready and busy are registered views of the next state.
  always_comb begin
    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
  end

  // State and registered outputs; async reset drops every valid/ready at once.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      state_q       <= ST_IDLE;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      wdog_q        <= '0;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      write_q       <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_write_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= 2'b00;
      rsp_timeout_q <= 1'b0;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      wdog_q        <= wdog_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      write_q       <= write_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_write_q   <= rsp_write_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
      cmd_ready_q   <= cmd_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign cmd_ready      = cmd_ready_q;
  assign busy           = busy_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_rdata      = rsp_rdata_q;
  assign rsp_resp       = rsp_resp_q;
  assign rsp_timeout    = rsp_timeout_q;
  assign m0_axi_awaddr  = addr_q;
  assign m0_axi_awvalid = awvalid_q;
  assign m0_axi_wdata   = wdata_q;
  assign m0_axi_wstrb   = wstrb_q;
  assign m0_axi_wvalid  = wvalid_q;
  assign m0_axi_bready  = bready_q;
  assign m0_axi_araddr  = addr_q;
  assign m0_axi_arvalid = arvalid_q;
  assign m0_axi_rready  = rready_q;

endmodule

// File: tb/tb_axil_master_port.sv
// Bench for axil_master_port: directed vector table, hand-written corner
// sequences and random commands against a word-memory reference model.
module tb_axil_master_port;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0;
  logic [7:0]  cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_wstrb = '0;
  logic        rsp_valid, rsp_ready = 1'b0, rsp_write, rsp_timeout, busy;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [7:0]  m0_awaddr, m0_araddr;
  logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
  logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
  logic [31:0] m0_wdata, m0_rdata;
  logic [3:0]  m0_wstrb;
  logic [1:0]  m0_bresp, m0_rresp;

  always #5 clk = ~clk;

  axil_master_port #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(16)) dut (
    .s0_axi_aclk(clk), .s0_axi_aresetn(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout), .busy(busy),
    .m0_axi_awaddr(m0_awaddr), .m0_axi_awvalid(m0_awvalid), .m0_axi_awready(m0_awready),
    .m0_axi_wdata(m0_wdata), .m0_axi_wstrb(m0_wstrb), .m0_axi_wvalid(m0_wvalid),
    .m0_axi_wready(m0_wready), .m0_axi_bresp(m0_bresp), .m0_axi_bvalid(m0_bvalid),
    .m0_axi_bready(m0_bready), .m0_axi_araddr(m0_araddr), .m0_axi_arvalid(m0_arvalid),
    .m0_axi_arready(m0_arready), .m0_axi_rdata(m0_rdata), .m0_axi_rresp(m0_rresp),
    .m0_axi_rvalid(m0_rvalid), .m0_axi_rready(m0_rready)
  );

  int total = 0;
  int bad = 0;

  // Slave configuration (written by the main thread only).
  int aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
  logic [1:0] b_code = 2'b00, r_code = 2'b00;
  bit silent = 1'b0, allow_wd = 1'b0;

  // Slave-owned state and monitor counters (written by the slave thread only).
  logic [31:0] mem_s [64];
  int aw_hi = 0, w_hi = 0, ar_hi = 0, b_hs = 0, r_hs = 0, prot_err = 0;

  // Reference model memory.
  logic [31:0] mem_m [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural AXI4-Lite slave with configurable ready/response delays, plus
  // a protocol monitor (no valid withdrawn or payload changed before handshake).
  initial begin : slave
    bit aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, b_act, r_act;
    bit pv_aw, pv_w, pv_ar;
    logic [7:0] pa_aw, pa_ar;
    logic [35:0] pa_w;
    logic [5:0] aw_a, ar_a;
    logic [31:0] w_data;
    logic [3:0] w_strb;
    int aw_c, w_c, b_c, ar_c, r_c;
    for (int i = 0; i < 64; i++) mem_s[i] = '0;
    {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, b_act, r_act} = '0;
    {pv_aw, pv_w, pv_ar} = '0;
    {aw_c, w_c, b_c, ar_c, r_c} = '0;
    aw_a = '0; ar_a = '0; w_data = '0; w_strb = '0; pa_aw = '0; pa_ar = '0; pa_w = '0;
    {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid} = '0;
    m0_bresp = '0; m0_rresp = '0; m0_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid} = '0;
        {aw_fire, w_fire, b_fire, ar_fire, r_fire, aw_got, w_got, b_act, r_act} = '0;
        {pv_aw, pv_w, pv_ar} = '0;
        {aw_c, w_c, b_c, ar_c, r_c} = '0;
      end else begin
        if (aw_fire) aw_got = 1'b1;
        if (w_fire) w_got = 1'b1;
        if (ar_fire) begin r_act = 1'b1; r_c = 0; end
        if (b_fire) begin b_act = 1'b0; b_hs++; end
        if (r_fire) begin r_act = 1'b0; r_hs++; end
        if (aw_got && w_got) begin
          for (int i = 0; i < 4; i++) if (w_strb[i]) mem_s[aw_a][8*i +: 8] = w_data[8*i +: 8];
          aw_got = 1'b0; w_got = 1'b0; b_act = 1'b1; b_c = 0;
        end
        m0_awready = !silent && m0_awvalid && (aw_c >= aw_dly);
        aw_c = m0_awvalid ? aw_c + 1 : 0;
        m0_wready = !silent && m0_wvalid && (w_c >= w_dly);
        w_c = m0_wvalid ? w_c + 1 : 0;
        m0_arready = !silent && m0_arvalid && (ar_c >= ar_dly);
        ar_c = m0_arvalid ? ar_c + 1 : 0;
        m0_bvalid = b_act && (b_c >= b_dly);
        if (b_act) b_c++;
        m0_bresp = b_code;
        m0_rvalid = r_act && (r_c >= r_dly);
        if (r_act) r_c++;
        m0_rresp = r_code;
        m0_rdata = m0_rvalid ? mem_s[ar_a] : 32'h0;
        aw_fire = m0_awvalid && m0_awready;
        if (aw_fire) aw_a = m0_awaddr[7:2];
        w_fire = m0_wvalid && m0_wready;
        if (w_fire) begin w_data = m0_wdata; w_strb = m0_wstrb; end
        ar_fire = m0_arvalid && m0_arready;
        if (ar_fire) ar_a = m0_araddr[7:2];
        b_fire = m0_bvalid && m0_bready;
        r_fire = m0_rvalid && m0_rready;
        if (m0_awvalid) aw_hi++;
        if (m0_wvalid) w_hi++;
        if (m0_arvalid) ar_hi++;
        if (pv_aw && !allow_wd && (!m0_awvalid || m0_awaddr != pa_aw)) prot_err++;
        if (pv_w && !allow_wd && (!m0_wvalid || {m0_wstrb, m0_wdata} != pa_w)) prot_err++;
        if (pv_ar && !allow_wd && (!m0_arvalid || m0_araddr != pa_ar)) prot_err++;
        pv_aw = m0_awvalid && !m0_awready; pa_aw = m0_awaddr;
        pv_w  = m0_wvalid && !m0_wready;   pa_w  = {m0_wstrb, m0_wdata};
        pv_ar = m0_arvalid && !m0_arready; pa_ar = m0_araddr;
      end
    end
  end

  // Issue one command at a negedge; latency counts cycles from accept (cycle 0)
  // to the first cycle rsp_valid is seen. Response is held for 'hold' cycles.
  task automatic run_cmd(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input logic [3:0] s, input int hold,
                         output logic [31:0] o_rdata, output logic [1:0] o_resp,
                         output logic o_write, output logic o_to, output int o_lat,
                         output int o_wait, output bit o_stable);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    o_wait = 0; o_lat = 0; o_stable = 1'b0;
    o_rdata = 'x; o_resp = 'x; o_write = 1'bx; o_to = 1'bx;
    while (!cmd_ready && o_wait < 50) begin @(negedge clk); o_wait++; end
    if (!cmd_ready) begin cmd_valid = 1'b0; o_lat = -1; return; end
    @(negedge clk);
    cmd_valid = 1'b0; cmd_addr = 8'hFF; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'h0;
    o_lat = 1;
    while (!rsp_valid && o_lat < 100) begin @(negedge clk); o_lat++; end
    if (!rsp_valid) begin o_lat = -1; return; end
    o_rdata = rsp_rdata; o_resp = rsp_resp; o_write = rsp_write; o_to = rsp_timeout;
    o_stable = !cmd_ready;
    for (int n = 0; n < hold; n++) begin
      @(negedge clk);
      if (!rsp_valid || cmd_ready || rsp_rdata !== o_rdata || rsp_resp !== o_resp ||
          rsp_write !== o_write || rsp_timeout !== o_to) o_stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (rsp_valid) o_stable = 1'b0;
  endtask

  task automatic model_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) mem_m[a[7:2]][8*i +: 8] = d[8*i +: 8];
  endtask

  // Run one command against the configured slave and check every observable.
  task automatic exec(input string tag, input bit wr, input logic [7:0] a,
                      input logic [31:0] d, input logic [3:0] s,
                      input int awd, input int wd, input int bd, input int ard, input int rd,
                      input logic [1:0] code, input int hold,
                      input logic [31:0] e_rdata, input logic [1:0] e_resp, input int e_lat);
    logic [31:0] o_rdata;
    logic [1:0] o_resp;
    logic o_write, o_to;
    int o_lat, o_wait, aw0, w0, ar0, b0, r0;
    bit o_stable;
    aw_dly = awd; w_dly = wd; b_dly = bd; ar_dly = ard; r_dly = rd;
    b_code = code; r_code = code;
    aw0 = aw_hi; w0 = w_hi; ar0 = ar_hi; b0 = b_hs; r0 = r_hs;
    run_cmd(wr, a, d, s, hold, o_rdata, o_resp, o_write, o_to, o_lat, o_wait, o_stable);
    chk($sformatf("%s.rdata", tag), o_rdata, e_rdata);
    chk($sformatf("%s.resp", tag), 32'(o_resp), 32'(e_resp));
    chk($sformatf("%s.write", tag), 32'(o_write), 32'(wr));
    chk($sformatf("%s.timeout", tag), 32'(o_to), 32'd0);
    chk($sformatf("%s.latency", tag), 32'(o_lat), 32'(e_lat));
    chk($sformatf("%s.rsp_stable", tag), 32'(o_stable), 32'd1);
    if (wr) begin
      chk($sformatf("%s.aw_cycles", tag), 32'(aw_hi - aw0), 32'(1 + awd));
      chk($sformatf("%s.w_cycles", tag), 32'(w_hi - w0), 32'(1 + wd));
      chk($sformatf("%s.b_handshakes", tag), 32'(b_hs - b0), 32'd1);
      model_write(a, d, s);
    end else begin
      chk($sformatf("%s.ar_cycles", tag), 32'(ar_hi - ar0), 32'(1 + ard));
      chk($sformatf("%s.r_handshakes", tag), 32'(r_hs - r0), 32'd1);
    end
  endtask

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          aw_d, w_d, b_d, ar_d, r_d;
    logic [1:0]  code;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t vecs [8];

  initial begin : main
    logic [31:0] o_rdata;
    logic [1:0] o_resp;
    logic o_write, o_to;
    int o_lat, o_wait, ar0, n;
    bit o_stable, seen;

    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    vecs[0] = '{1'b1, 8'h00, 32'h00056780, 4'hF, 0, 0, 0, 0, 0, 2'b00, 32'h0, 2'b00, 3};
    vecs[1] = '{1'b1, 8'h04, 32'h0005678A, 4'hF, 0, 3, 0, 0, 0, 2'b00, 32'h0, 2'b00, 6};
    vecs[2] = '{1'b0, 8'h04, 32'h0, 4'h0, 0, 0, 0, 0, 2, 2'b00, 32'h0005678A, 2'b00, 5};
    vecs[3] = '{1'b1, 8'h08, 32'hAABBCCDD, 4'h5, 0, 0, 1, 0, 0, 2'b10, 32'h0, 2'b10, 4};
    vecs[4] = '{1'b0, 8'h08, 32'h0, 4'h0, 0, 0, 0, 1, 0, 2'b01, 32'h00BB00DD, 2'b01, 4};
    vecs[5] = '{1'b0, 8'h00, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b11, 32'h00056780, 2'b11, 3};
    vecs[6] = '{1'b1, 8'h0C, 32'h11223344, 4'h8, 2, 0, 0, 0, 0, 2'b01, 32'h0, 2'b01, 5};
    vecs[7] = '{1'b0, 8'h0C, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 32'h11000000, 2'b00, 3};

    // Reset state.
    repeat (3) @(negedge clk);
    chk("reset.outputs", 32'({cmd_ready, busy, rsp_valid, m0_awvalid, m0_wvalid, m0_bready,
                              m0_arvalid, m0_rready, rsp_timeout, rsp_write}), 32'd0);
    chk("reset.rsp_rdata", rsp_rdata, 32'd0);
    rst_n = 1'b1;
    chk("reset.cmd_ready_at_release", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("reset.cmd_ready_after", 32'(cmd_ready), 32'd1);

    // Directed vector table.
    for (int i = 0; i < 8; i++)
      exec($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].data, vecs[i].strb,
           vecs[i].aw_d, vecs[i].w_d, vecs[i].b_d, vecs[i].ar_d, vecs[i].r_d, vecs[i].code,
           i % 3, vecs[i].exp_rdata, vecs[i].exp_resp, vecs[i].exp_lat);

    // Back-to-back: response held 5 cycles, next command accepted right after.
    exec("b2b.write", 1'b1, 8'h10, 32'hCAFEF00D, 4'hF, 0, 0, 0, 0, 0, 2'b00, 5,
         32'h0, 2'b00, 3);
    aw_dly = 0; ar_dly = 0; r_dly = 0; r_code = 2'b00;
    run_cmd(1'b0, 8'h10, 32'h0, 4'h0, 0, o_rdata, o_resp, o_write, o_to, o_lat, o_wait,
            o_stable);
    chk("b2b.accept_wait", 32'(o_wait), 32'd0);
    chk("b2b.read_rdata", o_rdata, 32'hCAFEF00D);

    // Watchdog on a silent slave.
    silent = 1'b1; allow_wd = 1'b1; ar0 = ar_hi;
    run_cmd(1'b0, 8'h10, 32'h0, 4'h0, 1, o_rdata, o_resp, o_write, o_to, o_lat, o_wait,
            o_stable);
    chk("tmo.ar_cycles", 32'(ar_hi - ar0), 32'd16);
    chk("tmo.resp", 32'(o_resp), 32'd2);
    chk("tmo.flag", 32'(o_to), 32'd1);
    chk("tmo.rdata", o_rdata, 32'd0);
    chk("tmo.latency", 32'(o_lat), 32'd17);
    silent = 1'b0; allow_wd = 1'b0;
    exec("tmo.recover", 1'b0, 8'h10, 32'h0, 4'h0, 0, 0, 0, 0, 1, 2'b00, 0,
         32'hCAFEF00D, 2'b00, 4);

    // Random commands against the reference model.
    for (int i = 0; i < 40; i++) begin
      bit wr;
      logic [7:0] a;
      logic [31:0] d, e_rdata;
      logic [3:0] s;
      logic [1:0] code;
      int awd, wd, bd, ard, rd, lat;
      wr = 1'($urandom_range(0, 1));
      a = 8'($urandom_range(0, 15) * 4);
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      code = 2'($urandom_range(0, 3));
      awd = $urandom_range(0, 3); wd = $urandom_range(0, 3); bd = $urandom_range(0, 3);
      ard = $urandom_range(0, 3); rd = $urandom_range(0, 3);
      if (wr) begin
        e_rdata = 32'h0;
        lat = 3 + ((awd > wd) ? awd : wd) + bd;
      end else begin
        e_rdata = mem_m[a[7:2]];
        lat = 3 + ard + rd;
      end
      exec($sformatf("rnd%0d", i), wr, a, d, s, awd, wd, bd, ard, rd, code,
           $urandom_range(0, 2), e_rdata, code, lat);
    end

    // Reset while waiting for the write response.
    aw_dly = 0; w_dly = 0; b_dly = 6; b_code = 2'b00;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 8'h20; cmd_wdata = 32'h5A5A5A5A;
    cmd_wstrb = 4'hF;
    n = 0;
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!m0_bready && n < 20) begin @(negedge clk); n++; end
    chk("rst.in_wr_resp", 32'(m0_bready), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst.async_drop", 32'({m0_bready, busy, rsp_valid, m0_awvalid, m0_wvalid,
                              m0_arvalid, m0_rready, cmd_ready}), 32'd0);
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid || busy || cmd_ready) seen = 1'b1;
    end
    chk("rst.held_quiet", 32'(seen), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst.cmd_ready", 32'(cmd_ready), 32'd1);
    exec("rst.fresh_write", 1'b1, 8'h20, 32'h13579BDF, 4'hF, 0, 0, 0, 0, 0, 2'b00, 0,
         32'h0, 2'b00, 3);
    exec("rst.readback", 1'b0, 8'h20, 32'h0, 4'h0, 0, 0, 0, 0, 0, 2'b00, 0,
         mem_m[8], 2'b00, 3);

    chk("protocol_violations", 32'(prot_err), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : time_limit
    #500000;
    $display("FAIL time_limit: got timeout expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
